// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel registered streaming mux.
package mux_pkg;

   localparam logic MODE_EXPLICIT = 1'b0;
   localparam logic MODE_RR       = 1'b1;
   localparam int   STAT_W        = 16;

   // Select width never collapses to zero, even for N = 1 or 2.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: first requester after ptr wins, wrapping modulo N.
module rr_arbiter_n
   import mux_pkg::*;
#(
   parameter  int N     = 4,
   localparam int SEL_W = sel_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   int k;

   // Scan from the far end back toward ptr+1 so the nearest requester is the last write.
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      k       = 0;
      for (int i = N; i >= 1; i--) begin
         k = (int'(ptr) + i) % N;
         if (req[k]) begin
            gnt_idx = SEL_W'(k);
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_n_reg.sv
// N-channel, W-bit streaming mux with valid/ready handshakes and a registered output.
// Optional MUX_N_REG_STAT_EN adds transfer and stall counters.
module mux_n_reg
   import mux_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int W     = 4,
   localparam int SEL_W = sel_width(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   input  logic [N*W-1:0]   i_data,
   input  logic [N-1:0]     i_valid,
   output logic [N-1:0]     i_ready,
   output logic [W-1:0]     o,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [SEL_W-1:0] o_chan
`ifdef MUX_N_REG_STAT_EN
   ,
   output logic [STAT_W-1:0] xfer_cnt,
   output logic [STAT_W-1:0] stall_cnt
`endif
);

   logic [W-1:0]     o_d, o_q;
   logic             o_valid_d, o_valid_q;
   logic [SEL_W-1:0] chan_d, chan_q;
   logic [SEL_W-1:0] ptr_d, ptr_q;

   logic             load_ok;
   logic             rr_vld, ex_vld, gnt_vld, xfer;
   logic [SEL_W-1:0] rr_idx, gnt_idx;
   logic [W-1:0]     gnt_data;

   rr_arbiter_n #(.N(N)) u_arb (
      .req     (i_valid),
      .ptr     (ptr_q),
      .gnt_idx (rr_idx),
      .gnt_vld (rr_vld)
   );

   always_comb begin
      load_ok = ~o_valid_q | o_ready;

      // An out-of-range sel matches no channel and simply yields no grant.
      ex_vld = 1'b0;
      for (int k = 0; k < N; k++)
         if (sel == SEL_W'(k)) ex_vld = i_valid[k];

      gnt_vld = (mode == MODE_RR) ? rr_vld : ex_vld;
      gnt_idx = (mode == MODE_RR) ? rr_idx : sel;
      xfer    = gnt_vld & load_ok & ~reset;

      i_ready  = '0;
      gnt_data = '0;
      for (int k = 0; k < N; k++) begin
         if (gnt_idx == SEL_W'(k)) begin
            i_ready[k] = xfer;
            gnt_data   = i_data[k*W +: W];
         end
      end

      o_d       = o_q;
      o_valid_d = o_valid_q;
      chan_d    = chan_q;
      ptr_d     = ptr_q;
      if (xfer) begin
         o_d       = gnt_data;
         o_valid_d = 1'b1;
         chan_d    = gnt_idx;
         if (mode == MODE_RR) ptr_d = gnt_idx;
      end else if (load_ok) begin
         o_valid_d = 1'b0;
      end
   end

   // ptr resets to N-1 so the first round-robin scan starts at channel 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_q       <= '0;
         o_valid_q <= 1'b0;
         chan_q    <= '0;
         ptr_q     <= SEL_W'(N-1);
      end else begin
         o_q       <= o_d;
         o_valid_q <= o_valid_d;
         chan_q    <= chan_d;
         ptr_q     <= ptr_d;
      end
   end

   assign o       = o_q;
   assign o_valid = o_valid_q;
   assign o_chan  = chan_q;

`ifdef MUX_N_REG_STAT_EN
   logic [STAT_W-1:0] xfer_cnt_d, xfer_cnt_q;
   logic [STAT_W-1:0] stall_cnt_d, stall_cnt_q;

   // Transfer count wraps; stall count sticks at all-ones.
   always_comb begin
      xfer_cnt_d  = xfer_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (xfer) xfer_cnt_d = xfer_cnt_q + 1'b1;
      if (o_valid_q && !o_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         xfer_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         xfer_cnt_q  <= xfer_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign xfer_cnt  = xfer_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed, table-driven bench for mux_n_reg (N=4 main instance, N=3 for out-of-range select).
module tb_mux_n_reg;
   import mux_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        mode;
   logic [1:0]  sel;
   logic [15:0] i_data;
   logic [3:0]  i_valid, i_ready;
   logic [3:0]  o;
   logic        o_valid, o_ready;
   logic [1:0]  o_chan;

   logic        mode3;
   logic [1:0]  sel3;
   logic [11:0] i_data3;
   logic [2:0]  i_valid3, i_ready3;
   logic [3:0]  o3;
   logic        o_valid3, o_ready3;
   logic [1:0]  o_chan3;

`ifdef MUX_N_REG_STAT_EN
   logic [15:0] xfer_cnt, stall_cnt, xfer_cnt3, stall_cnt3;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux_n_reg #(.N(4), .W(4)) u_dut (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel), .i_data(i_data),
      .i_valid(i_valid), .i_ready(i_ready), .o(o), .o_valid(o_valid),
      .o_ready(o_ready), .o_chan(o_chan)
`ifdef MUX_N_REG_STAT_EN
      , .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
`endif
   );

   mux_n_reg #(.N(3), .W(4)) u_dut3 (
      .clk(clk), .reset(reset), .mode(mode3), .sel(sel3), .i_data(i_data3),
      .i_valid(i_valid3), .i_ready(i_ready3), .o(o3), .o_valid(o_valid3),
      .o_ready(o_ready3), .o_chan(o_chan3)
`ifdef MUX_N_REG_STAT_EN
      , .xfer_cnt(xfer_cnt3), .stall_cnt(stall_cnt3)
`endif
   );

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [15:0] dat;
      logic [3:0]  vld;
      logic        ordy;
      logic [3:0]  e_rdy;
      logic [3:0]  e_o;
      logic        e_ov;
      logic [1:0]  e_ch;
   } vec_t;

   vec_t vt[17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic m, input logic [1:0] s, input logic [15:0] d,
                        input logic [3:0] v, input logic r);
      mode = m; sel = s; i_data = d; i_valid = v; o_ready = r;
   endtask

   initial begin
      // Continuous sequence from reset (ptr = 3, output empty).
      vt[0]  = '{MODE_RR, 2'd0, 16'h4321, 4'b1111, 1'b1, 4'b0001, 4'h1, 1'b1, 2'd0};
      vt[1]  = '{MODE_RR, 2'd0, 16'h4321, 4'b1111, 1'b1, 4'b0010, 4'h2, 1'b1, 2'd1};
      vt[2]  = '{MODE_RR, 2'd0, 16'h4321, 4'b1111, 1'b1, 4'b0100, 4'h3, 1'b1, 2'd2};
      vt[3]  = '{MODE_RR, 2'd0, 16'h4321, 4'b1111, 1'b1, 4'b1000, 4'h4, 1'b1, 2'd3};
      vt[4]  = '{MODE_RR, 2'd0, 16'h4321, 4'b1111, 1'b1, 4'b0001, 4'h1, 1'b1, 2'd0};
      vt[5]  = '{MODE_EXPLICIT, 2'd2, 16'h0A00, 4'b0100, 1'b1, 4'b0100, 4'hA, 1'b1, 2'd2};
      vt[6]  = '{MODE_EXPLICIT, 2'd1, 16'h0030, 4'b0010, 1'b1, 4'b0010, 4'h3, 1'b1, 2'd1};
      vt[7]  = '{MODE_EXPLICIT, 2'd0, 16'hFFFF, 4'b1111, 1'b0, 4'b0000, 4'h3, 1'b1, 2'd1};
      vt[8]  = '{MODE_EXPLICIT, 2'd2, 16'h1234, 4'b1111, 1'b0, 4'b0000, 4'h3, 1'b1, 2'd1};
      vt[9]  = '{MODE_RR,       2'd3, 16'h9876, 4'b1111, 1'b0, 4'b0000, 4'h3, 1'b1, 2'd1};
      vt[10] = '{MODE_EXPLICIT, 2'd3, 16'h5000, 4'b1111, 1'b1, 4'b1000, 4'h5, 1'b1, 2'd3};
      vt[11] = '{MODE_EXPLICIT, 2'd0, 16'hEEEE, 4'b0000, 1'b1, 4'b0000, 4'h5, 1'b0, 2'd3};
      vt[12] = '{MODE_RR, 2'd0, 16'h0090, 4'b0010, 1'b0, 4'b0010, 4'h9, 1'b1, 2'd1};
      vt[13] = '{MODE_RR, 2'd0, 16'h7006, 4'b1001, 1'b1, 4'b1000, 4'h7, 1'b1, 2'd3};
      vt[14] = '{MODE_RR, 2'd0, 16'h7006, 4'b1001, 1'b1, 4'b0001, 4'h6, 1'b1, 2'd0};
      vt[15] = '{MODE_EXPLICIT, 2'd3, 16'h8888, 4'b1000, 1'b0, 4'b0000, 4'h6, 1'b1, 2'd0};
      vt[16] = '{MODE_RR, 2'd0, 16'h4321, 4'b1111, 1'b1, 4'b0010, 4'h2, 1'b1, 2'd1};

      mode3 = MODE_EXPLICIT; sel3 = 2'd0; i_data3 = '0; i_valid3 = '0; o_ready3 = 1'b1;

      // Reset with every channel requesting.
      reset = 1'b1;
      drive(MODE_RR, 2'd0, 16'h4321, 4'b1111, 1'b1);
      #1 chk("rst_i_ready", 32'(i_ready), 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_o", 32'(o), 32'h0);
      chk("rst_o_valid", 32'(o_valid), 32'h0);
      chk("rst_o_chan", 32'(o_chan), 32'h0);
      chk("rst_i_ready2", 32'(i_ready), 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         drive(vt[i].mode, vt[i].sel, vt[i].dat, vt[i].vld, vt[i].ordy);
         #1 chk($sformatf("v%0d_i_ready", i), 32'(i_ready), 32'(vt[i].e_rdy));
         @(posedge clk); #1;
         chk($sformatf("v%0d_o", i), 32'(o), 32'(vt[i].e_o));
         chk($sformatf("v%0d_o_valid", i), 32'(o_valid), 32'(vt[i].e_ov));
         chk($sformatf("v%0d_o_chan", i), 32'(o_chan), 32'(vt[i].e_ch));
      end

      // Reset during a stall drops the held word.
      drive(MODE_RR, 2'd0, 16'h4321, 4'b1111, 1'b0);
      @(posedge clk); #1;
      chk("stall_hold_o", 32'(o), 32'h2);
      reset   = 1'b1;
      o_ready = 1'b1;
      #1 chk("midrst_i_ready", 32'(i_ready), 32'h0);
      @(posedge clk); #1;
      chk("midrst_o", 32'(o), 32'h0);
      chk("midrst_o_valid", 32'(o_valid), 32'h0);
      chk("midrst_o_chan", 32'(o_chan), 32'h0);
      reset = 1'b0;

      // Ten back-to-back round-robin transfers, then four stall cycles.
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk($sformatf("b2b%0d_o_chan", i), 32'(o_chan), 32'(i % 4));
         chk($sformatf("b2b%0d_o", i), 32'(o), 32'((i % 4) + 1));
         chk($sformatf("b2b%0d_o_valid", i), 32'(o_valid), 32'h1);
      end
      o_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1 chk($sformatf("stl%0d_i_ready", i), 32'(i_ready), 32'h0);
         @(posedge clk); #1;
         chk($sformatf("stl%0d_o", i), 32'(o), 32'h2);
      end
`ifdef MUX_N_REG_STAT_EN
      chk("xfer_cnt", 32'(xfer_cnt), 32'd10);
      chk("stall_cnt", 32'(stall_cnt), 32'd4);
`endif
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst2_o_valid", 32'(o_valid), 32'h0);
`ifdef MUX_N_REG_STAT_EN
      chk("xfer_cnt_rst", 32'(xfer_cnt), 32'd0);
      chk("stall_cnt_rst", 32'(stall_cnt), 32'd0);
`endif
      i_valid = 4'b0000;

      // N=3: a valid load, then sel=3 is out of range and drains the output.
      mode3 = MODE_EXPLICIT; sel3 = 2'd1; i_data3 = 12'h050; i_valid3 = 3'b111; o_ready3 = 1'b1;
      #1 chk("n3_load_i_ready", 32'(i_ready3), 32'h2);
      @(posedge clk); #1;
      chk("n3_load_o", 32'(o3), 32'h5);
      chk("n3_load_o_valid", 32'(o_valid3), 32'h1);
      chk("n3_load_o_chan", 32'(o_chan3), 32'h1);
      sel3 = 2'd3; i_data3 = 12'hABC;
      #1 chk("n3_oor_i_ready", 32'(i_ready3), 32'h0);
      @(posedge clk); #1;
      chk("n3_oor_o_valid", 32'(o_valid3), 32'h0);
      chk("n3_oor_o", 32'(o3), 32'h5);
      chk("n3_oor_o_chan", 32'(o_chan3), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
